multiplexor_display: RTL and testbench

//  Drives the board's time-multiplexed 7-segment displays and the status LEDs from the ALU's registered outputs.

---
 rtl/display_pkg.sv | 26 ++
 rtl/multiplexor_display_if.sv | 33 +++
 rtl/decodificador_7seg.sv | 15 +
 rtl/multiplexor_display.sv | 188 ++++++++++++++++++
 tb/tb_multiplexor_display.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module : display_pkg
// Brief  : Scan FSM states, hex to 7-segment table and LED bit positions.
// Rev    : 1.0
// ============================================================================
package display_pkg;

  typedef enum logic [0:0] {
    ESCANEO   = 1'b0,
    PENDIENTE = 1'b1
  } estado_t;

  // {g,f,e,d,c,b,a} active-low; entry n is the glyph for hex digit n
  localparam logic [15:0][6:0] c_hex_7seg = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam int c_led_carry = 0;
  localparam int c_led_cero  = 1;
  localparam int c_led_neg   = 2;
  localparam int c_led_desb  = 3;

endpackage
`default_nettype wire

// File: rtl/multiplexor_display_if.sv
`default_nettype none
// ============================================================================
// Module : multiplexor_display_if
// Brief  : ALU-side capture inputs and board-side display/LED outputs.
// Rev    : 1.0
// ============================================================================
interface multiplexor_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 4 * NUM_DIGITS
);
  logic                  actualizar;
  logic [DATA_W-1:0]     dato;
  logic                  selector_led_display;
  logic                  carry;
  logic                  cero;
  logic                  negativo;
  logic                  desbordamiento;
  logic [NUM_DIGITS-1:0] anodos;
  logic [6:0]            segmentos;
  logic [3:0]            leds;
  logic                  listo;

  modport master (
    output actualizar, dato, selector_led_display, carry, cero, negativo, desbordamiento,
    input  anodos, segmentos, leds, listo
  );

  modport slave (
    input  actualizar, dato, selector_led_display, carry, cero, negativo, desbordamiento,
    output anodos, segmentos, leds, listo
  );
endinterface
`default_nettype wire

// File: rtl/decodificador_7seg.sv
`default_nettype none
// ============================================================================
// Module : decodificador_7seg
// Brief  : Combinational hex nibble to active-low 7-segment pattern.
// Rev    : 1.0
// ============================================================================
module decodificador_7seg
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segmentos
);
  assign o_segmentos = c_hex_7seg[i_nibble];
endmodule
`default_nettype wire

// File: rtl/multiplexor_display.sv
`default_nettype none
// ============================================================================
// Module : multiplexor_display
// Brief  : Frame-synchronous capture and multiplexed scan of 7-seg digits/LEDs.
//          Optional overflow blink: define BLINK_ON_OVERFLOW_EN.
// Rev    : 1.0
// ============================================================================
module multiplexor_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DATA_W       = 4 * NUM_DIGITS,
  parameter int PRESCALE     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  multiplexor_display_if.slave bus
);
  localparam int c_presc_w = $clog2(PRESCALE);
  localparam int c_idx_w   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(PRESCALE - 1);
  localparam logic [c_idx_w-1:0]   c_idx_max   = c_idx_w'(NUM_DIGITS - 1);

  generate
    if (PRESCALE < 2 || DATA_W != 4 * NUM_DIGITS || BLINK_FRAMES < 1) begin : g_param_invalido
      $error("multiplexor_display: invalid parameter set");
    end
  endgenerate

  logic [c_presc_w-1:0]  r_presc;
  logic [c_idx_w-1:0]    r_idx;
  logic                  w_vuelta;
  logic                  w_fin_trama;
  estado_t               r_estado;
  estado_t               w_estado_sig;
  logic                  w_cargar;
  logic                  w_commit;
  logic                  w_bypass;
  logic [3:0]            w_flags_in;
  logic [DATA_W-1:0]     r_st_dato;
  logic                  r_st_sel;
  logic [3:0]            r_st_flags;
  logic [DATA_W-1:0]     r_sh_dato;
  logic                  r_sh_sel;
  logic [3:0]            r_sh_flags;
  logic [3:0]            w_nibble;
  logic [6:0]            w_seg_dec;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic                  w_parpadeo;
  logic [NUM_DIGITS-1:0] r_anodos;
  logic [6:0]            r_segmentos;
  logic                  r_listo;

  assign w_vuelta    = (r_presc == c_presc_max);
  assign w_fin_trama = w_vuelta && (r_idx == c_idx_max);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_vuelta) begin
      r_presc <= '0;
      r_idx   <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    w_flags_in              = '0;
    w_flags_in[c_led_carry] = bus.carry;
    w_flags_in[c_led_cero]  = bus.cero;
    w_flags_in[c_led_neg]   = bus.negativo;
    w_flags_in[c_led_desb]  = bus.desbordamiento;
  end

  always_ff @(posedge clock) begin
    if (reset) r_estado <= ESCANEO;
    else       r_estado <= w_estado_sig;
  end

  // A strobe landing on the commit edge goes straight to the shadow copy
  always_comb begin
    w_estado_sig = r_estado;
    w_cargar     = 1'b0;
    w_commit     = 1'b0;
    w_bypass     = 1'b0;
    case (r_estado)
      ESCANEO: begin
        if (bus.actualizar) begin
          w_cargar     = 1'b1;
          w_estado_sig = PENDIENTE;
        end
      end
      PENDIENTE: begin
        if (w_fin_trama) begin
          w_commit     = 1'b1;
          w_bypass     = bus.actualizar;
          w_estado_sig = ESCANEO;
        end else if (bus.actualizar) begin
          w_cargar = 1'b1;
        end
      end
      default: w_estado_sig = ESCANEO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_st_dato  <= '0;
      r_st_sel   <= 1'b0;
      r_st_flags <= '0;
      r_sh_dato  <= '0;
      r_sh_sel   <= 1'b0;
      r_sh_flags <= '0;
      r_listo    <= 1'b0;
    end else begin
      r_listo <= w_commit;
      if (w_cargar) begin
        r_st_dato  <= bus.dato;
        r_st_sel   <= bus.selector_led_display;
        r_st_flags <= w_flags_in;
      end
      if (w_commit) begin
        r_sh_dato  <= w_bypass ? bus.dato                 : r_st_dato;
        r_sh_sel   <= w_bypass ? bus.selector_led_display : r_st_sel;
        r_sh_flags <= w_bypass ? w_flags_in               : r_st_flags;
      end
    end
  end

`ifdef BLINK_ON_OVERFLOW_EN
  localparam int c_frm_w = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [c_frm_w-1:0] c_frm_max = c_frm_w'(BLINK_FRAMES - 1);

  logic [c_frm_w-1:0] r_tramas;
  logic               r_fase;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tramas <= '0;
      r_fase   <= 1'b0;
    end else if (w_fin_trama) begin
      if (r_tramas == c_frm_max) begin
        r_tramas <= '0;
        r_fase   <= ~r_fase;
      end else begin
        r_tramas <= r_tramas + 1'b1;
      end
    end
  end

  assign w_parpadeo = r_sh_flags[c_led_desb] & r_fase;
`else
  assign w_parpadeo = 1'b0;
`endif

  assign w_nibble = r_sh_dato[{r_idx, 2'b00} +: 4];

  decodificador_7seg u_decodificador (
    .i_nibble    (w_nibble),
    .o_segmentos (w_seg_dec)
  );

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

  // Counters keep running while blanked so re-enabling stays frame aligned
  always_ff @(posedge clock) begin
    if (reset) begin
      r_anodos    <= '1;
      r_segmentos <= 7'h7F;
    end else begin
      r_segmentos <= w_seg_dec;
      r_anodos    <= (!r_sh_sel || w_parpadeo) ? '1 : ~w_onehot;
    end
  end

  assign bus.anodos    = r_anodos;
  assign bus.segmentos = r_segmentos;
  assign bus.leds      = r_sh_flags;
  assign bus.listo     = r_listo;

endmodule
`default_nettype wire

// File: tb/tb_multiplexor_display.sv
`default_nettype none
// ============================================================================
// Module : tb_multiplexor_display
// Brief  : Random + directed stimulus against a frame-arithmetic reference model.
// Rev    : 1.0
// ============================================================================
module tb_multiplexor_display;
  localparam int ND  = 4;
  localparam int DW  = 16;
  localparam int PRE = 4;
  localparam int BF  = 2;
  localparam int FRM = PRE * ND;
`ifdef BLINK_ON_OVERFLOW_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] dato;
    logic          sel;
    logic [3:0]    flags;   // {desbordamiento, negativo, cero, carry}
  } rec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multiplexor_display_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus ();

  multiplexor_display #(
    .NUM_DIGITS(ND), .DATA_W(DW), .PRESCALE(PRE), .BLINK_FRAMES(BF)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [6:0] tb_hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int checks = 0;
  int errors = 0;
  int n_listo = 0;
  rec_t exp_q[$];

  // Reference model state
  bit         m_armed = 1'b0;
  int         m_n = 0;
  bit         m_pend = 1'b0;
  rec_t       m_st = '0;
  rec_t       m_sh = '0;
  int         m_frames = 0;
  bit         m_phase = 1'b0;
  logic [3:0] e_anod = 4'hF;
  logic [6:0] e_seg = 7'h7F;
  bit         e_seg_chk = 1'b1;
  logic       e_listo = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // Frame timing is pure arithmetic on the count of non-reset edges
  initial begin : model
    rec_t in_r;
    int   dig;
    bit   fe;
    forever begin
      @(posedge clock);
      if (reset) begin
        m_armed = 1'b1; m_n = 0; m_pend = 1'b0; m_st = '0; m_sh = '0;
        m_frames = 0; m_phase = 1'b0;
        e_anod = 4'hF; e_seg = 7'h7F; e_seg_chk = 1'b1; e_listo = 1'b0;
      end else begin
        dig  = (m_n / PRE) % ND;
        fe   = (m_n % FRM) == FRM - 1;
        in_r = {bus.dato, bus.selector_led_display,
                bus.desbordamiento, bus.negativo, bus.cero, bus.carry};
        if (!m_sh.sel || (BLINK && m_sh.flags[3] && m_phase)) begin
          e_anod = 4'hF; e_seg_chk = 1'b0;
        end else begin
          e_anod = ~(4'b0001 << dig); e_seg_chk = 1'b1;
          e_seg  = tb_hex[m_sh.dato[dig*4 +: 4]];
        end
        e_listo = 1'b0;
        if (m_pend && fe) begin
          m_sh = bus.actualizar ? in_r : m_st;
          m_pend = 1'b0; e_listo = 1'b1;
          exp_q.push_back(m_sh);
        end else if (bus.actualizar) begin
          m_st = in_r; m_pend = 1'b1;
        end
        if (fe) begin
          m_frames++;
          if (m_frames == BF) begin m_frames = 0; m_phase = !m_phase; end
        end
        m_n++;
      end
    end
  end

  initial begin : monitor
    rec_t r;
    forever begin
      @(negedge clock);
      if (m_armed) begin
        chk("anodos", 32'(bus.anodos), 32'(e_anod));
        if (e_seg_chk) chk("segmentos", 32'(bus.segmentos), 32'(e_seg));
        chk("leds", 32'(bus.leds), 32'(m_sh.flags));
        chk("listo", 32'(bus.listo), 32'(e_listo));
        if (bus.listo === 1'b1) begin
          n_listo++;
          chk("listo_has_commit", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("commit_leds", 32'(bus.leds), 32'(r.flags));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic s, input logic [3:0] f);
    bus.dato = d;
    bus.selector_led_display = s;
    {bus.desbordamiento, bus.negativo, bus.cero, bus.carry} = f;
  endtask

  task automatic pulse(input logic [DW-1:0] d, input logic s, input logic [3:0] f);
    drive(d, s, f);
    bus.actualizar = 1'b1;
    tick();
    bus.actualizar = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 2 * FRM && (m_n % FRM) != ph; i++) tick();
    chk("wait_phase", 32'(m_n % FRM), 32'(ph));
  endtask

  initial begin : stimulus
    int base;
    bus.actualizar = 1'b0;
    drive('0, 1'b0, 4'b0000);
    // 1: reset held three cycles
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_anodos", 32'(bus.anodos), 32'hF);
    chk("rst_segmentos", 32'(bus.segmentos), 32'h7F);
    chk("rst_leds", 32'(bus.leds), 32'h0);
    chk("rst_listo", 32'(bus.listo), 32'h0);
    reset = 1'b0;

    // 2: single capture commits at the first frame end
    base = n_listo;
    pulse(16'h1234, 1'b1, 4'b0000);
    repeat (2 * FRM) tick();
    chk("s2_listo_count", 32'(n_listo - base), 32'd1);

    // 3: two strobes within one frame, latest wins
    wait_phase(2);
    base = n_listo;
    pulse(16'h1111, 1'b1, 4'b0000);
    wait_phase(8);
    pulse(16'hABCD, 1'b1, 4'b0000);
    repeat (2 * FRM) tick();
    chk("s3_listo_count", 32'(n_listo - base), 32'd1);

    // 4: displays blanked, carry and negativo lit
    wait_phase(3);
    pulse(16'h5A5A, 1'b0, 4'b0101);
    repeat (2 * FRM) tick();
    chk("s4_leds", 32'(bus.leds), 32'h5);
    chk("s4_anodos", 32'(bus.anodos), 32'hF);

    // 5: reset just before the frame end drops the pending capture
    wait_phase(5);
    base = n_listo;
    pulse(16'h7777, 1'b1, 4'b1111);
    wait_phase(FRM - 2);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2 * FRM) tick();
    chk("s5_listo_count", 32'(n_listo - base), 32'd0);
    chk("s5_leds", 32'(bus.leds), 32'h0);
    pulse(16'h0F1E, 1'b1, 4'b0000);
    repeat (2 * FRM) tick();

    // 6: overflow flag set with displays on
    pulse(16'hF00D, 1'b1, 4'b1000);
    repeat (8 * FRM) tick();
    chk("s6_leds", 32'(bus.leds), 32'h8);

    // random traffic, occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(399, 0) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(3, 1)) tick();
        reset = 1'b0;
      end else begin
        drive(DW'($urandom), ($urandom_range(3, 0) != 0), 4'($urandom));
        bus.actualizar = ($urandom_range(5, 0) == 0);
        tick();
      end
    end
    bus.actualizar = 1'b0;
    repeat (2 * FRM) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
